// File: rtl/imem_loader.sv
// imem_loader: frames a UART byte stream (start, length, data, checksum) and
// writes 32-bit big-endian words into the instruction RAM, holding busy high
// so fetch stays stalled while a load is in progress.
//
// Ports:
//   clk       - clock, rising edge
//   rst_n     - synchronous active-low reset
//   rx_data   - received byte
//   rx_valid  - one-cycle strobe qualifying rx_data
//   we        - instruction RAM write enable (one pulse per word)
//   waddr     - RAM word address, valid while we=1
//   wdata     - instruction word, valid while we=1
//   busy      - load in progress
//   done      - sticky: last frame completed with a good checksum
//   err       - sticky: last frame failed its checksum
module imem_loader #(
  parameter logic [7:0] START_BYTE = 8'h55,
  parameter logic [8:0] ADDR_BASE  = 9'h000,
  parameter logic [8:0] ADDR_STEP  = 9'd1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        we,
  output logic [8:0]  waddr,
  output logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int unsigned ADDR_W = 9;
  localparam int unsigned LEN_W  = 9;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned SHR_W  = WORD_W - BYTE_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_CHK
  } state_t;

  state_t              state_q, state_n;
  logic [LEN_W-1:0]    len_q, len_n;
  logic [LEN_W-1:0]    idx_q, idx_n;
  logic [1:0]          bcnt_q, bcnt_n;
  logic [SHR_W-1:0]    shift_q, shift_n;
  logic [BYTE_W-1:0]   csum_q, csum_n;
  logic                we_n;
  logic [ADDR_W-1:0]   waddr_n;
  logic [WORD_W-1:0]   wdata_n;
  logic                busy_n, done_n, err_n;
  logic [LEN_W-1:0]    idx_inc;
  logic [LEN_W-1:0]    len_lo_val;

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      bcnt_q  <= '0;
      shift_q <= '0;
      csum_q  <= '0;
      we      <= 1'b0;
      waddr   <= '0;
      wdata   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state_q <= state_n;
      len_q   <= len_n;
      idx_q   <= idx_n;
      bcnt_q  <= bcnt_n;
      shift_q <= shift_n;
      csum_q  <= csum_n;
      we      <= we_n;
      waddr   <= waddr_n;
      wdata   <= wdata_n;
      busy    <= busy_n;
      done    <= done_n;
      err     <= err_n;
    end
  end

  assign idx_inc    = idx_q + LEN_W'(1);
  assign len_lo_val = {len_q[8], rx_data};

  // Next-state, frame parsing and word assembly
  always_comb begin
    state_n = state_q;
    len_n   = len_q;
    idx_n   = idx_q;
    bcnt_n  = bcnt_q;
    shift_n = shift_q;
    csum_n  = csum_q;
    we_n    = 1'b0;
    waddr_n = waddr;
    wdata_n = wdata;
    busy_n  = busy;
    done_n  = done;
    err_n   = err;

    if (rx_valid) begin
      unique case (state_q)
        S_IDLE: begin
          if (rx_data == START_BYTE) begin
            done_n  = 1'b0;
            err_n   = 1'b0;
            csum_n  = '0;
            idx_n   = '0;
            bcnt_n  = '0;
            busy_n  = 1'b1;
            state_n = S_LEN_HI;
          end
        end
        S_LEN_HI: begin
          // Only bit 0 carries length; the whole byte still enters the checksum
          len_n   = {rx_data[0], 8'h00};
          csum_n  = csum_q ^ rx_data;
          state_n = S_LEN_LO;
        end
        S_LEN_LO: begin
          len_n   = len_lo_val;
          csum_n  = csum_q ^ rx_data;
          bcnt_n  = '0;
          state_n = (len_lo_val == LEN_W'(0)) ? S_CHK : S_DATA;
        end
        S_DATA: begin
          csum_n = csum_q ^ rx_data;
          if (bcnt_q == 2'd3) begin
            we_n    = 1'b1;
            waddr_n = ADDR_W'(ADDR_BASE + idx_q * ADDR_STEP);
            wdata_n = {shift_q, rx_data};
            idx_n   = idx_inc;
            bcnt_n  = '0;
            if (idx_inc == len_q) state_n = S_CHK;
          end else begin
            shift_n = {shift_q[SHR_W-BYTE_W-1:0], rx_data};
            bcnt_n  = bcnt_q + 2'd1;
          end
        end
        S_CHK: begin
          if (rx_data == csum_q) done_n = 1'b1;
          else                   err_n  = 1'b1;
          busy_n  = 1'b0;
          state_n = S_IDLE;
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: directed frames from the test plan plus random
// frames checked against a frame-level reference model.
module tb_imem_loader;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, rx_valid;
  logic [7:0]  rx_data;
  logic        we, busy, done, err;
  logic [8:0]  waddr;
  logic [31:0] wdata;

  logic        rst_n_w, rx_valid_w;
  logic [7:0]  rx_data_w;
  logic        we_w, busy_w, done_w, err_w;
  logic [8:0]  waddr_w;
  logic [31:0] wdata_w;

  imem_loader dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .we(we), .waddr(waddr), .wdata(wdata), .busy(busy), .done(done), .err(err)
  );

  imem_loader #(.ADDR_BASE(9'h1FF)) dut_w (
    .clk(clk), .rst_n(rst_n_w), .rx_data(rx_data_w), .rx_valid(rx_valid_w),
    .we(we_w), .waddr(waddr_w), .wdata(wdata_w), .busy(busy_w), .done(done_w), .err(err_w)
  );

  int errors = 0;
  int checks = 0;

  logic [40:0] got_w[$];
  logic [40:0] got_ww[$];
  logic [40:0] exp_w[$];
  logic [7:0]  sent[$];
  int          busy_cnt, busy_cnt_w;
  logic        m_done, m_err, m_busy;

  // Capture every RAM write and count busy cycles
  always @(negedge clk) begin
    if (we)     got_w.push_back({waddr, wdata});
    if (we_w)   got_ww.push_back({waddr_w, wdata_w});
    if (busy)   busy_cnt++;
    if (busy_w) busy_cnt_w++;
  end

  task automatic send(input logic [7:0] b, input int gap, input bit w);
    if (w) begin rx_data_w = b; rx_valid_w = 1'b1; end
    else   begin rx_data   = b; rx_valid   = 1'b1; end
    @(negedge clk);
    rx_valid   = 1'b0;
    rx_valid_w = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  // Frame-level model: scan for START, take length, data words, checksum
  task automatic model_run(input logic [8:0] base);
    int i, n, len;
    logic [7:0]  cs;
    logic [31:0] word;
    bit stop;
    exp_w.delete();
    n = sent.size();
    i = 0;
    stop = 0;
    while (i < n && !stop) begin
      if (sent[i] != 8'h55) begin
        i++;
      end else begin
        m_done = 0; m_err = 0; m_busy = 1;
        i++;
        if (i + 2 > n) stop = 1;
        else begin
          len = 256 * int'(sent[i] & 8'h01) + int'(sent[i+1]);
          cs  = sent[i] ^ sent[i+1];
          i += 2;
          for (int k = 0; k < len && !stop; k++) begin
            if (i + 4 > n) stop = 1;
            else begin
              word = {sent[i], sent[i+1], sent[i+2], sent[i+3]};
              cs   = cs ^ sent[i] ^ sent[i+1] ^ sent[i+2] ^ sent[i+3];
              exp_w.push_back({9'((int'(base) + k) % 512), word});
              i += 4;
            end
          end
          if (!stop) begin
            if (i >= n) stop = 1;
            else begin
              m_done = (sent[i] == cs);
              m_err  = !m_done;
              m_busy = 0;
              i++;
            end
          end
        end
      end
    end
  endtask

  task automatic play(input bit w, input int max_gap);
    got_w.delete();
    got_ww.delete();
    busy_cnt = 0;
    busy_cnt_w = 0;
    foreach (sent[i]) send(sent[i], (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0, w);
    @(negedge clk);
    model_run(w ? 9'h1FF : 9'h000);
  endtask

  task automatic test_reset;
    rst_n = 0; rst_n_w = 0; rx_valid = 0; rx_valid_w = 0; rx_data = 0; rx_data_w = 0;
    repeat (2) @(negedge clk);
    checks++; if (we !== 1'b0)      begin errors++; $display("FAIL reset_we got=%b exp=0", we); end
    checks++; if (waddr !== 9'h0)   begin errors++; $display("FAIL reset_waddr got=%h exp=0", waddr); end
    checks++; if (wdata !== 32'h0)  begin errors++; $display("FAIL reset_wdata got=%h exp=0", wdata); end
    checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0)    begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (err !== 1'b0)     begin errors++; $display("FAIL reset_err got=%b exp=0", err); end
    rst_n = 1; rst_n_w = 1;
    m_done = 0; m_err = 0; m_busy = 0;
    @(negedge clk);
  endtask

  task automatic test_two_word(input logic [7:0] csum, input bit good);
    sent = '{8'h55, 8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0, csum};
    play(0, 0);
    checks++; if (got_w.size() != 2) begin errors++; $display("FAIL two_word_count got=%0d exp=2", got_w.size()); end
    checks++; if (got_w.size() > 0 && got_w[0] !== {9'h000, 32'h12345678})
      begin errors++; $display("FAIL two_word_w0 got=%h exp=%h", got_w[0], {9'h000, 32'h12345678}); end
    checks++; if (got_w.size() > 1 && got_w[1] !== {9'h001, 32'h9ABCDEF0})
      begin errors++; $display("FAIL two_word_w1 got=%h exp=%h", got_w[1], {9'h001, 32'h9ABCDEF0}); end
    checks++; if (busy_cnt != 11) begin errors++; $display("FAIL two_word_busy_cycles got=%0d exp=11", busy_cnt); end
    checks++; if (done !== good)  begin errors++; $display("FAIL two_word_done got=%b exp=%b", done, good); end
    checks++; if (err !== !good)  begin errors++; $display("FAIL two_word_err got=%b exp=%b", err, !good); end
  endtask

  task automatic test_zero_len;
    sent = '{8'h55, 8'h00, 8'h00, 8'h00};
    play(0, 0);
    checks++; if (got_w.size() != 0) begin errors++; $display("FAIL zero_len_writes got=%0d exp=0", got_w.size()); end
    checks++; if (busy_cnt != 3)     begin errors++; $display("FAIL zero_len_busy got=%0d exp=3", busy_cnt); end
    checks++; if (done !== 1'b1 || err !== 1'b0)
      begin errors++; $display("FAIL zero_len_status got done=%b err=%b exp done=1 err=0", done, err); end
  endtask

  task automatic test_reset_mid_data;
    sent = '{8'h55, 8'h00, 8'h01, 8'hAA, 8'hBB};
    play(0, 0);
    checks++; if (got_w.size() != 0) begin errors++; $display("FAIL mid_reset_prewrites got=%0d exp=0", got_w.size()); end
    checks++; if (busy !== 1'b1)     begin errors++; $display("FAIL mid_reset_busy_before got=%b exp=1", busy); end
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    m_done = 0; m_err = 0; m_busy = 0;
    checks++; if ({we, waddr, wdata, busy, done, err} !== '0)
      begin errors++; $display("FAIL mid_reset_outputs got we=%b waddr=%h wdata=%h busy=%b done=%b err=%b exp all 0",
                               we, waddr, wdata, busy, done, err); end
    sent = '{8'hCC, 8'hDD};
    play(0, 0);
    checks++; if (got_w.size() != 0 || busy_cnt != 0)
      begin errors++; $display("FAIL mid_reset_after got writes=%0d busy_cycles=%0d exp 0 0", got_w.size(), busy_cnt); end
    checks++; if (done !== m_done) begin errors++; $display("FAIL mid_reset_done got=%b exp=%b", done, m_done); end
  endtask

  task automatic test_idle_garbage_restart;
    // 00^01^DE^AD^BE^EF = 23
    sent = '{8'h00, 8'hFF, 8'h12, 8'h55, 8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h23};
    play(0, 3);
    checks++; if (got_w.size() != 1) begin errors++; $display("FAIL garbage_count got=%0d exp=1", got_w.size()); end
    checks++; if (got_w.size() > 0 && got_w[0] !== {9'h000, 32'hDEADBEEF})
      begin errors++; $display("FAIL garbage_word got=%h exp=%h", got_w[0], {9'h000, 32'hDEADBEEF}); end
    checks++; if (done !== 1'b1 || err !== 1'b0)
      begin errors++; $display("FAIL garbage_status got done=%b err=%b exp done=1 err=0", done, err); end
    send(8'h55, 0, 0);
    checks++; if (done !== 1'b0 || busy !== 1'b1)
      begin errors++; $display("FAIL restart_clear got done=%b busy=%b exp done=0 busy=1", done, busy); end
    send(8'h00, 0, 0); send(8'h00, 0, 0); send(8'h00, 0, 0);
    checks++; if (done !== 1'b1 || busy !== 1'b0)
      begin errors++; $display("FAIL restart_finish got done=%b busy=%b exp done=1 busy=0", done, busy); end
  endtask

  task automatic test_random;
    for (int f = 0; f < 15; f++) begin
      int len;
      logic [7:0] hi, cs, b;
      sent.delete();
      repeat ($urandom_range(2, 0)) begin
        b = 8'($urandom);
        sent.push_back((b == 8'h55) ? 8'h56 : b);
      end
      sent.push_back(8'h55);
      len = int'($urandom_range(5, 0));
      hi  = 8'($urandom) & 8'hFE;
      sent.push_back(hi);
      sent.push_back(8'(len));
      cs = hi ^ 8'(len);
      for (int k = 0; k < 4 * len; k++) begin
        b = 8'($urandom);
        sent.push_back(b);
        cs = cs ^ b;
      end
      if ($urandom_range(9, 0) < 7) sent.push_back(cs);
      else sent.push_back(cs ^ 8'($urandom_range(255, 1)));
      play(0, 2);
      checks++; if (got_w.size() != exp_w.size())
        begin errors++; $display("FAIL rand%0d_count got=%0d exp=%0d", f, got_w.size(), exp_w.size()); end
      foreach (exp_w[i]) begin
        checks++;
        if (i >= got_w.size() || got_w[i] !== exp_w[i])
          begin errors++; $display("FAIL rand%0d_word%0d got=%h exp=%h", f, i,
                                   (i < got_w.size()) ? got_w[i] : 41'h0, exp_w[i]); end
      end
      checks++; if (done !== m_done || err !== m_err || busy !== m_busy)
        begin errors++; $display("FAIL rand%0d_status got done=%b err=%b busy=%b exp done=%b err=%b busy=%b",
                                 f, done, err, busy, m_done, m_err, m_busy); end
    end
  endtask

  task automatic test_wrap;
    sent = '{8'h55, 8'h01, 8'h02};
    repeat (8) sent.push_back(8'($urandom));
    play(1, 0);
    checks++; if (got_ww.size() != 2) begin errors++; $display("FAIL wrap_count got=%0d exp=2", got_ww.size()); end
    foreach (exp_w[i]) begin
      checks++;
      if (i >= got_ww.size() || got_ww[i] !== exp_w[i])
        begin errors++; $display("FAIL wrap_word%0d got=%h exp=%h", i,
                                 (i < got_ww.size()) ? got_ww[i] : 41'h0, exp_w[i]); end
    end
    checks++; if (got_ww.size() > 1 && (got_ww[0][40:32] !== 9'h1FF || got_ww[1][40:32] !== 9'h000))
      begin errors++; $display("FAIL wrap_addr got=%h,%h exp=1ff,000", got_ww[0][40:32], got_ww[1][40:32]); end
    checks++; if (busy_w !== 1'b1) begin errors++; $display("FAIL wrap_busy got=%b exp=1", busy_w); end
    rst_n_w = 0;
    @(negedge clk);
    rst_n_w = 1;
    checks++; if ({we_w, waddr_w, wdata_w, busy_w, done_w, err_w} !== '0)
      begin errors++; $display("FAIL wrap_reset got we=%b waddr=%h wdata=%h busy=%b done=%b err=%b exp all 0",
                               we_w, waddr_w, wdata_w, busy_w, done_w, err_w); end
  endtask

  initial begin
    test_reset();
    test_two_word(8'h02, 1'b1);
    test_two_word(8'h03, 1'b0);
    test_zero_len();
    test_reset_mid_data();
    test_idle_garbage_restart();
    test_random();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
